// File: rtl/instruction_loader.sv
// rtl/instruction_loader.sv - byte-stream to instruction RAM loader (optional checksum via LOADER_CHECKSUM_EN)
// Packs four big-endian bytes per word and writes consecutive words from a base address.
module instruction_loader #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  physical_clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] word_count,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic                  ram_write_flag,
    output logic [ADDR_WIDTH-1:0] ram_write_addr,
    output logic [DATA_WIDTH-1:0] ram_write_data,
    output logic                  hold_cpu,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] words_written,
    output logic                  checksum_error
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        WRITE = 3'd2,
`ifdef LOADER_CHECKSUM_EN
        CHECK = 3'd3,
`endif
        DONE  = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   base_q, base_d;
    logic [ADDR_WIDTH-1:0]   count_q, count_d;
    logic [ADDR_WIDTH-1:0]   words_q, words_d;
    logic [1:0]              idx_q, idx_d;
    logic [DATA_WIDTH-9:0]   buf_q, buf_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    flag_q, flag_d;
    logic                    hold_q, hold_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    start_acc;
    logic                    byte_acc;
    logic [ADDR_WIDTH-1:0]   words_inc;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]              csum_q, csum_d;
    logic                    err_q, err_d;
`endif

    assign start_acc = start && (state_q == IDLE || state_q == DONE);
    assign byte_acc  = byte_valid && byte_ready;
    assign words_inc = words_q + ADDR_WIDTH'(1);

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        count_d = count_q;
        words_d = words_q;
        idx_d   = idx_q;
        buf_d   = buf_q;
        addr_d  = addr_q;
        data_d  = data_q;
        flag_d  = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        csum_d  = csum_q;
        err_d   = err_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    base_d  = base_addr;
                    count_d = word_count;
                    words_d = '0;
                    idx_d   = '0;
`ifdef LOADER_CHECKSUM_EN
                    csum_d  = '0;
                    err_d   = 1'b0;
`endif
                    state_d = (word_count == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                if (byte_acc) begin
                    buf_d = {buf_q[DATA_WIDTH-17:0], byte_data};
                    idx_d = idx_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                    csum_d = csum_q ^ byte_data;
`endif
                    // Fourth byte goes straight into the write register, not the shift buffer.
                    if (idx_q == 2'd3) begin
                        state_d = WRITE;
                        flag_d  = 1'b1;
                        addr_d  = base_q + words_q;
                        data_d  = {buf_q, byte_data};
                    end
                end
            end
            WRITE: begin
                words_d = words_inc;
                if (words_inc == count_q) begin
`ifdef LOADER_CHECKSUM_EN
                    state_d = CHECK;
`else
                    state_d = DONE;
`endif
                end else begin
                    state_d = LOAD;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CHECK: begin
                if (byte_acc) begin
                    err_d   = (byte_data != csum_q);
                    state_d = DONE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE) && (state_d != DONE);
        // A zero-length load still holds the core for the acceptance cycle.
        hold_d = busy_d || start_acc;
        done_d = (state_d == DONE) && !start_acc;
    end

    always_ff @(posedge physical_clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            base_q  <= '0;
            count_q <= '0;
            words_q <= '0;
            idx_q   <= '0;
            buf_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            flag_q  <= 1'b0;
            hold_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum_q  <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            count_q <= count_d;
            words_q <= words_d;
            idx_q   <= idx_d;
            buf_q   <= buf_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            flag_q  <= flag_d;
            hold_q  <= hold_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q  <= csum_d;
            err_q   <= err_d;
`endif
        end
    end

`ifdef LOADER_CHECKSUM_EN
    assign byte_ready     = (state_q == LOAD) || (state_q == CHECK);
    assign checksum_error = err_q;
`else
    assign byte_ready     = (state_q == LOAD);
    assign checksum_error = 1'b0;
`endif

    assign ram_write_flag = flag_q;
    assign ram_write_addr = addr_q;
    assign ram_write_data = data_q;
    assign hold_cpu       = hold_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign words_written  = words_q;

endmodule

// File: tb/tb_instruction_loader.sv
// tb/tb_instruction_loader.sv - self-checking bench for instruction_loader
module tb_instruction_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] base_addr;
    logic [15:0] word_count;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        ram_write_flag;
    logic [15:0] ram_write_addr;
    logic [31:0] ram_write_data;
    logic        hold_cpu;
    logic        busy;
    logic        done;
    logic [15:0] words_written;
    logic        checksum_error;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [15:0] base;
        logic [15:0] count;
        logic [63:0] bytes;
        bit          gaps;
        bit          poke;
    } vec_t;

    vec_t tbl[4];
    logic [47:0] exp_q[$];

    instruction_loader dut (
        .physical_clock (clk),
        .reset          (reset),
        .start          (start),
        .base_addr      (base_addr),
        .word_count     (word_count),
        .byte_valid     (byte_valid),
        .byte_data      (byte_data),
        .byte_ready     (byte_ready),
        .ram_write_flag (ram_write_flag),
        .ram_write_addr (ram_write_addr),
        .ram_write_data (ram_write_data),
        .hold_cpu       (hold_cpu),
        .busy           (busy),
        .done           (done),
        .words_written  (words_written),
        .checksum_error (checksum_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (ram_write_flag) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {16'h0, ram_write_addr, ram_write_data}, 64'hDEAD);
            end else begin
                logic [47:0] e;
                e = exp_q.pop_front();
                check("write_addr", ram_write_addr, e[47:32]);
                check("write_data", ram_write_data, e[31:0]);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit gaps, input bit poke);
        if (gaps) begin
            int g;
            g = $urandom_range(0, 3);
            for (int i = 0; i < g; i++) begin
                if (poke && i == 0) start = 1'b1;
                tick();
                start = 1'b0;
            end
        end
        byte_valid = 1'b1;
        byte_data  = b;
        for (int i = 0; i < 20 && !byte_ready; i++) tick();
        if (!byte_ready) check("byte_ready_timeout", 0, 1);
        tick();
        byte_valid = 1'b0;
    endtask

    task automatic do_start(input logic [15:0] b, input logic [15:0] c);
        base_addr  = b;
        word_count = c;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 50 && !done; i++) tick();
    endtask

    task automatic run_vec(input vec_t v);
        logic [7:0] b;
        logic [7:0] x;
        logic [31:0] w;
        x = 8'h00;
        do_start(v.base, v.count);
        check("busy_after_start", busy, 1);
        check("hold_after_start", hold_cpu, 1);
        check("ready_after_start", byte_ready, 1);
        for (int i = 0; i < 4 * int'(v.count); i++) begin
            b = v.bytes[63 - 8*i -: 8];
            x = x ^ b;
            w = {w[23:0], b};
            if (i % 4 == 3) exp_q.push_back({v.base + 16'(i / 4), w});
            send_byte(b, v.gaps, v.poke);
        end
`ifdef LOADER_CHECKSUM_EN
        send_byte(x, 1'b0, 1'b0);
`endif
        wait_done();
        tick();
        check("done", done, 1);
        check("hold_in_done", hold_cpu, 0);
        check("busy_in_done", busy, 0);
        check("words_written", words_written, v.count);
        check("checksum_error", checksum_error, 0);
        check("writes_pending", exp_q.size(), 0);
    endtask

    initial begin
        tbl[0] = '{16'h0010, 16'd2, 64'h12345678_9ABCDEF0, 1'b0, 1'b0};
        tbl[1] = '{16'hFFFF, 16'd2, 64'h00112233_44556677, 1'b0, 1'b0};
        tbl[2] = '{16'h0010, 16'd2, 64'h12345678_9ABCDEF0, 1'b1, 1'b1};
        tbl[3] = '{16'h1234, 16'd1, 64'hDEADBEEF_00000000, 1'b1, 1'b0};

        reset = 1'b1; start = 1'b0; base_addr = '0; word_count = '0;
        byte_valid = 1'b0; byte_data = '0;
        #1;
        check("rst_outputs", {byte_ready, ram_write_flag, hold_cpu, busy, done, checksum_error}, 0);
        check("rst_values", {ram_write_addr, ram_write_data, words_written}, 0);
        tick();
        reset = 1'b0;
        tick();

        for (int k = 0; k < 4; k++) run_vec(tbl[k]);

        // zero-length load: one-cycle hold, done a cycle later, no writes
        do_start(16'h0040, 16'd0);
        check("zero_hold", hold_cpu, 1);
        check("zero_done_early", done, 0);
        tick();
        check("zero_done", done, 1);
        check("zero_hold_off", hold_cpu, 0);
        check("zero_words", words_written, 0);

        // reset after 6 of 8 bytes: only the first word lands
        do_start(16'h0020, 16'd2);
        exp_q.push_back({16'h0020, 32'hA1B2C3D4});
        send_byte(8'hA1, 0, 0); send_byte(8'hB2, 0, 0);
        send_byte(8'hC3, 0, 0); send_byte(8'hD4, 0, 0);
        send_byte(8'hE5, 0, 0); send_byte(8'hF6, 0, 0);
        reset = 1'b1;
        #1;
        check("midrst_outputs", {byte_ready, ram_write_flag, hold_cpu, busy, done, checksum_error}, 0);
        check("midrst_values", {ram_write_addr, ram_write_data, words_written}, 0);
        check("midrst_pending", exp_q.size(), 0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("midrst_idle", {busy, done, byte_ready}, 0);
        run_vec(tbl[0]);

`ifdef LOADER_CHECKSUM_EN
        do_start(16'h0100, 16'd1);
        exp_q.push_back({16'h0100, 32'h01020304});
        send_byte(8'h01, 0, 0); send_byte(8'h02, 0, 0);
        send_byte(8'h03, 0, 0); send_byte(8'h04, 0, 0);
        send_byte(8'h05, 0, 0);
        wait_done();
        check("csum_bad_done", done, 1);
        check("csum_bad_flag", checksum_error, 1);
        check("csum_bad_words", words_written, 1);
        do_start(16'h0100, 16'd1);
        check("csum_cleared", checksum_error, 0);
        exp_q.push_back({16'h0100, 32'h01020304});
        send_byte(8'h01, 0, 0); send_byte(8'h02, 0, 0);
        send_byte(8'h03, 0, 0); send_byte(8'h04, 0, 0);
        send_byte(8'h04, 0, 0);
        wait_done();
        check("csum_ok_done", done, 1);
        check("csum_ok_flag", checksum_error, 0);
`endif

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
